bcd_counter_n: RTL

Parametrised multi-digit synchronous BCD counter that counts up or down, loads a value, and wraps or saturates.
- Every digit is updated on the same clock edge. No digit is clocked from a lower digit's carry.
- It is the general counting primitive for display, timer and event-count paths.
- Terminal-count output allows wider cascaded chains.

---
 rtl/bcd_counter_n.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bcd_counter_n.sv
// Multi-digit synchronous BCD up/down counter with parallel load, a
// combinational terminal count for cascading, and one-cycle pulses for
// limit events (ovf) and rejected loads (load_err). All digits share one
// clock edge; carries and borrows are resolved combinationally.
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] CNT_MAX = {DIGITS{4'h9}};
    localparam logic [W-1:0] CNT_MIN = '0;

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         load_err_q, load_err_d;
    logic         load_ok;
    logic         at_limit;

    // True when every nibble of v is a legal decimal digit.
    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Decimal increment: a digit steps only while every lower digit is 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decimal decrement: a digit steps only while every lower digit is 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Limit detection and terminal count; tc feeds the next cascaded stage.
    always_comb begin
        load_ok  = all_bcd(load_val);
        at_limit = up_dn ? (count_q == CNT_MAX) : (count_q == CNT_MIN);
        tc       = en & ~load & at_limit;
    end

    // Next-state selection: load beats count; a limit hit raises ovf.
    always_comb begin
        count_d    = count_q;
        ovf_d      = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (at_limit) begin
                ovf_d = 1'b1;
                if (WRAP) begin
                    count_d = up_dn ? CNT_MIN : CNT_MAX;
                end
            end else begin
                count_d = up_dn ? bcd_inc(count_q) : bcd_dec(count_q);
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule
